mem_port_arbiter: RTL and testbench

Shares the single backing-memory port (mem_addr/mem_in/mem_out/mem_out_valid/mem_wrreq/mem_rdreq) between the instruction-cache refill path and the data-cache refill/writeback path. It sits between the hybrid cache's two miss engines and the memory model or controller. It accepts one transfer at a time, issues it to memory as a single-cycle strobe, and returns read data to the owning requester.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between icache refill and dcache refill/writeback.
// Define MEMARB_ROUNDROBIN_EN for round-robin IC/DC arbitration; default is DC priority.
module mem_port_arbiter #(
  parameter int ADDRBITS  = 32,
  parameter int DATABITS  = 32,
  parameter int MEM_RDLAT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDRBITS-1:0] ic_rdaddr,
  input  logic                ic_rdreq,
  output logic                ic_rd_ready,
  output logic [DATABITS-1:0] ic_out,
  output logic                ic_out_valid,
  input  logic [ADDRBITS-1:0] dc_rdaddr,
  input  logic                dc_rdreq,
  output logic                dc_rd_ready,
  output logic [DATABITS-1:0] dc_out,
  output logic                dc_out_valid,
  input  logic [ADDRBITS-1:0] dc_wraddr,
  input  logic                dc_wrreq,
  input  logic [DATABITS-1:0] dc_in,
  output logic                dc_wr_ready,
  output logic                dc_wr_done,
  output logic [ADDRBITS-1:0] mem_addr,
  output logic [DATABITS-1:0] mem_in,
  input  logic [DATABITS-1:0] mem_out,
  input  logic                mem_out_valid,
  output logic                mem_rdreq,
  output logic                mem_wrreq
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam logic [3:0] LAT0 = 4'(MEM_RDLAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       own_dc;
  logic       is_wr;

  logic go;
  logic dc_any;
  logic ic_pri;
  logic ic_win;
  logic dc_win;
  logic acc;

  assign go     = reset_n & (state == IDLE);
  assign dc_any = dc_wrreq | dc_rdreq;

`ifdef MEMARB_ROUNDROBIN_EN
  logic ic_turn;

  // IC wins the first conflict out of reset, then turns alternate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ic_turn <= 1'b1;
    end else if (acc) begin
      ic_turn <= ~ic_rd_ready;
    end
  end

  assign ic_pri = ic_turn;
`else
  assign ic_pri = 1'b0;
`endif

  assign ic_win      = ic_rdreq & (ic_pri | ~dc_any);
  assign dc_win      = dc_any & ~ic_win;
  assign ic_rd_ready = go & ic_win;
  assign dc_wr_ready = go & dc_win & dc_wrreq;
  assign dc_rd_ready = go & dc_win & ~dc_wrreq;
  assign acc         = ic_rd_ready | dc_wr_ready | dc_rd_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      own_dc       <= 1'b0;
      is_wr        <= 1'b0;
      mem_addr     <= '0;
      mem_in       <= '0;
      mem_rdreq    <= 1'b0;
      mem_wrreq    <= 1'b0;
      dc_wr_done   <= 1'b0;
      ic_out       <= '0;
      ic_out_valid <= 1'b0;
      dc_out       <= '0;
      dc_out_valid <= 1'b0;
    end else begin
      mem_rdreq    <= 1'b0;
      mem_wrreq    <= 1'b0;
      dc_wr_done   <= 1'b0;
      ic_out_valid <= 1'b0;
      dc_out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc) begin
            state     <= ISSUE;
            own_dc    <= ~ic_rd_ready;
            is_wr     <= dc_wr_ready;
            mem_wrreq <= dc_wr_ready;
            mem_rdreq <= ~dc_wr_ready;
            unique case (1'b1)
              ic_rd_ready: mem_addr <= ic_rdaddr;
              dc_wr_ready: begin
                mem_addr <= dc_wraddr;
                mem_in   <= dc_in;
              end
              default: mem_addr <= dc_rdaddr;
            endcase
          end
        end
        ISSUE: begin
          if (is_wr) begin
            dc_wr_done <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt   <= LAT0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (mem_out_valid) begin
            if (own_dc) begin
              dc_out       <= mem_out;
              dc_out_valid <= 1'b1;
            end else begin
              ic_out       <= mem_out;
              ic_out_valid <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: writes, reads, conflicts, latency, reset.
// dut runs MEM_RDLAT=1 against a small memory model; xdut runs MEM_RDLAT=3.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ic_rdaddr, dc_rdaddr, dc_wraddr, dc_in;
  logic        ic_rdreq, dc_rdreq, dc_wrreq;
  logic [31:0] mem_out;
  logic        mem_out_valid;
  logic        vlow;

  logic        ic_rd_ready, ic_out_valid, dc_rd_ready, dc_out_valid;
  logic        dc_wr_ready, dc_wr_done, mem_rdreq, mem_wrreq;
  logic [31:0] ic_out, dc_out, mem_addr, mem_in;

  logic        x_ic_rd_ready, x_ic_out_valid, x_dc_rd_ready, x_dc_out_valid;
  logic        x_dc_wr_ready, x_dc_wr_done, x_mem_rdreq, x_mem_wrreq;
  logic [31:0] x_ic_out, x_dc_out, x_mem_addr, x_mem_in;

  logic [31:0] mem [16];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        first_dc;

  always #5 clk = ~clk;

  assign mem_out_valid = ~vlow;

  mem_port_arbiter #(.ADDRBITS(32), .DATABITS(32), .MEM_RDLAT(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .ic_rdaddr(ic_rdaddr), .ic_rdreq(ic_rdreq), .ic_rd_ready(ic_rd_ready),
    .ic_out(ic_out), .ic_out_valid(ic_out_valid),
    .dc_rdaddr(dc_rdaddr), .dc_rdreq(dc_rdreq), .dc_rd_ready(dc_rd_ready),
    .dc_out(dc_out), .dc_out_valid(dc_out_valid),
    .dc_wraddr(dc_wraddr), .dc_wrreq(dc_wrreq), .dc_in(dc_in),
    .dc_wr_ready(dc_wr_ready), .dc_wr_done(dc_wr_done),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out),
    .mem_out_valid(mem_out_valid), .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq)
  );

  mem_port_arbiter #(.ADDRBITS(32), .DATABITS(32), .MEM_RDLAT(3)) xdut (
    .clk(clk), .reset_n(reset_n),
    .ic_rdaddr(ic_rdaddr), .ic_rdreq(ic_rdreq), .ic_rd_ready(x_ic_rd_ready),
    .ic_out(x_ic_out), .ic_out_valid(x_ic_out_valid),
    .dc_rdaddr(dc_rdaddr), .dc_rdreq(dc_rdreq), .dc_rd_ready(x_dc_rd_ready),
    .dc_out(x_dc_out), .dc_out_valid(x_dc_out_valid),
    .dc_wraddr(dc_wraddr), .dc_wrreq(dc_wrreq), .dc_in(dc_in),
    .dc_wr_ready(x_dc_wr_ready), .dc_wr_done(x_dc_wr_done),
    .mem_addr(x_mem_addr), .mem_in(x_mem_in), .mem_out(mem_out),
    .mem_out_valid(mem_out_valid), .mem_rdreq(x_mem_rdreq), .mem_wrreq(x_mem_wrreq)
  );

  // Zero-wait memory: word N preloads to 0xA000000N while in reset.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      mem_out <= '0;
    end else begin
      if (mem_wrreq) mem[mem_addr[5:2]] <= mem_in;
      if (mem_rdreq) mem_out <= mem[mem_addr[5:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    ic_rdreq = 0;
    dc_rdreq = 0;
    dc_wrreq = 0;
    vlow     = 0;
    reset_n  = 0;
    tick();
    tick();
    reset_n = 1;
    tick();
  endtask

  initial begin
`ifdef MEMARB_ROUNDROBIN_EN
    first_dc = 1'b0;
`else
    first_dc = 1'b1;
`endif
    reset_n   = 0;
    vlow      = 0;
    ic_rdaddr = '0;
    dc_rdaddr = '0;
    dc_wraddr = '0;
    dc_in     = '0;
    ic_rdreq  = 0;
    dc_rdreq  = 0;
    dc_wrreq  = 1;
    tick();
    check("rst_wr_ready", dc_wr_ready, 0);
    check("rst_wrreq", mem_wrreq, 0);
    check("rst_rdreq", mem_rdreq, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_in", mem_in, 0);
    check("rst_dc_out", dc_out, 0);
    check("rst_ic_out", ic_out, 0);
    check("rst_dc_vld", dc_out_valid, 0);
    check("rst_done", dc_wr_done, 0);
    dc_wrreq = 0;
    reset_n  = 1;
    tick();

    // single write
    dc_wraddr = 32'h8000_0000;
    dc_in     = 32'h0fff_0001;
    dc_wrreq  = 1;
    #1;
    check("w_ready", dc_wr_ready, 1);
    check("w_ic_ready", ic_rd_ready, 0);
    tick();
    dc_wrreq = 0;
    check("w_strobe", mem_wrreq, 1);
    check("w_rd_strobe", mem_rdreq, 0);
    check("w_addr", mem_addr, 32'h8000_0000);
    check("w_data", mem_in, 32'h0fff_0001);
    check("w_done_c1", dc_wr_done, 0);
    tick();
    check("w_strobe_c2", mem_wrreq, 0);
    check("w_done_c2", dc_wr_done, 1);
    check("w_addr_hold", mem_addr, 32'h8000_0000);
    tick();
    check("w_done_c3", dc_wr_done, 0);

    // read back
    dc_rdaddr = 32'h8000_0000;
    dc_rdreq  = 1;
    #1;
    check("r_ready", dc_rd_ready, 1);
    tick();
    dc_rdreq = 0;
    check("r_strobe", mem_rdreq, 1);
    check("r_addr", mem_addr, 32'h8000_0000);
    tick();
    check("r_strobe_c2", mem_rdreq, 0);
    check("r_vld_c2", dc_out_valid, 0);
    tick();
    check("r_vld_c3", dc_out_valid, 1);
    check("r_data", dc_out, 32'h0fff_0001);
    check("r_ic_vld", ic_out_valid, 0);
    tick();
    check("r_vld_c4", dc_out_valid, 0);
    check("r_data_hold", dc_out, 32'h0fff_0001);

    // IC/DC conflict
    do_reset();
    ic_rdaddr = 32'h8000_0004;
    dc_rdaddr = 32'h8000_0008;
    ic_rdreq  = 1;
    dc_rdreq  = 1;
    #1;
    check("cf_dc_ready", dc_rd_ready, first_dc);
    check("cf_ic_ready", ic_rd_ready, !first_dc);
    tick();
    if (first_dc) dc_rdreq = 0;
    else ic_rdreq = 0;
    check("cf_addr1", mem_addr, first_dc ? 32'h8000_0008 : 32'h8000_0004);
    check("cf_busy_ready", ic_rd_ready | dc_rd_ready, 0);
    tick();
    tick();
    check("cf_dc_vld1", dc_out_valid, first_dc);
    check("cf_ic_vld1", ic_out_valid, !first_dc);
    check("cf_dc_ready2", dc_rd_ready, !first_dc);
    check("cf_ic_ready2", ic_rd_ready, first_dc);
    tick();
    ic_rdreq = 0;
    dc_rdreq = 0;
    check("cf_strobe2", mem_rdreq, 1);
    check("cf_addr2", mem_addr, first_dc ? 32'h8000_0004 : 32'h8000_0008);
    tick();
    tick();
    check("cf_ic_vld2", ic_out_valid, first_dc);
    check("cf_dc_vld2", dc_out_valid, !first_dc);
    check("cf_ic_data", ic_out, 32'hA000_0001);
    check("cf_dc_data", dc_out, 32'hA000_0002);

    // write and read raised together
    tick();
    dc_wraddr = 32'h8000_000C;
    dc_in     = 32'h1234_5678;
    dc_rdaddr = 32'h8000_000C;
    dc_wrreq  = 1;
    dc_rdreq  = 1;
    #1;
    check("wr_rd_wready", dc_wr_ready, 1);
    check("wr_rd_rready", dc_rd_ready, 0);
    tick();
    dc_wrreq = 0;
    check("wr_rd_wstrobe", mem_wrreq, 1);
    check("wr_rd_rstrobe", mem_rdreq, 0);
    tick();
    check("wr_rd_done", dc_wr_done, 1);
    check("wr_rd_rready2", dc_rd_ready, 1);
    tick();
    dc_rdreq = 0;
    check("wr_rd_rstrobe2", mem_rdreq, 1);
    check("wr_rd_addr", mem_addr, 32'h8000_000C);
    tick();
    tick();
    check("wr_rd_vld", dc_out_valid, 1);
    check("wr_rd_data", dc_out, 32'h1234_5678);

    // MEM_RDLAT=3 with valid held low two extra cycles
    do_reset();
    dc_rdaddr = 32'h8000_0000;
    dc_rdreq  = 1;
    #1;
    check("lat_ready", x_dc_rd_ready, 1);
    tick();
    dc_rdreq = 0;
    check("lat_strobe", x_mem_rdreq, 1);
    tick();
    tick();
    tick();
    vlow = 1;
    check("lat_vld_c4", x_dc_out_valid, 0);
    tick();
    check("lat_vld_c5", x_dc_out_valid, 0);
    tick();
    vlow = 0;
    check("lat_vld_c6", x_dc_out_valid, 0);
    tick();
    check("lat_vld_c7", x_dc_out_valid, 1);
    check("lat_data", x_dc_out, 32'hA000_0000);
    tick();
    check("lat_vld_c8", x_dc_out_valid, 0);

    // reset while waiting on memory
    vlow      = 1;
    dc_rdaddr = 32'h8000_0004;
    dc_rdreq  = 1;
    tick();
    dc_rdreq = 0;
    check("rw_strobe", mem_rdreq, 1);
    tick();
    tick();
    reset_n = 0;
    #1;
    check("rw_rst_strobe", mem_rdreq, 0);
    check("rw_rst_vld", dc_out_valid, 0);
    check("rw_rst_data", dc_out, 0);
    vlow = 0;
    tick();
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rw_no_vld", dc_out_valid | ic_out_valid, 0);
    end
    dc_rdreq = 1;
    #1;
    check("rw_idle_ready", dc_rd_ready, 1);
    tick();
    dc_rdreq = 0;
    tick();
    tick();
    check("rw_new_vld", dc_out_valid, 1);
    check("rw_new_data", dc_out, 32'hA000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
